// File: rtl/lut_cfg_loader_if.sv
// Configuration bus between the serial config shift path and the LUT/MUX/FF
// block's loader: serial bit input with its valid strobe, and the parallel
// configuration word plus status pulses coming back out.
//   master : the side that shifts bits in and consumes INIT/S (bench / fabric)
//   slave  : lut_cfg_loader itself
interface lut_cfg_loader_if #(
    parameter int K = 4
);
    logic              DI;
    logic              DV;
    logic [2**K-1:0]   INIT;
    logic              S;
    logic              DONE;
    logic              ERR;
    logic              BUSY;

    modport master (
        output DI,
        output DV,
        input  INIT,
        input  S,
        input  DONE,
        input  ERR,
        input  BUSY
    );

    modport slave (
        input  DI,
        input  DV,
        output INIT,
        output S,
        output DONE,
        output ERR,
        output BUSY
    );
endinterface

// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: serial configuration writer for the LUT/MUX/FF block.
// Hunts a SYNC_W-bit sync word in the DV-qualified bit stream, then
// deserialises 2**K truth-table bits (MSB first) followed by the mux select
// bit, and commits them to the registered INIT/S outputs only once the whole
// frame has arrived, so the block never sees a partially written table.
//
// Optional build macro LUT_CFG_LOADER_PARITY_EN: appends one even-parity bit
// to each frame, adds a CHECK state and pulses ERR on a parity mismatch
// (frame discarded). Without it ERR is constantly 0 and every frame commits.
module lut_cfg_loader #(
    parameter int                K      = 4,
    parameter int                SYNC_W = 8,
    parameter logic [SYNC_W-1:0] SYNC   = 8'hA5
) (
    input  logic                C,
    input  logic                RN,
    lut_cfg_loader_if.slave     bus
);

    localparam int             INIT_W   = 2**K;
    localparam int             CW       = $clog2(INIT_W + 1);
    // Index of the S bit inside the payload; consuming it ends the LOAD phase.
    localparam logic [CW-1:0]  LAST_IDX = CW'(INIT_W);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_LOAD  = 2'd1
`ifdef LUT_CFG_LOADER_PARITY_EN
        ,
        ST_CHECK = 2'd2
`endif
    } state_t;

`ifdef LUT_CFG_LOADER_PARITY_EN
    // Even parity over payload plus parity bit: any odd count of ones is bad.
    function automatic logic parity_bad(input logic [INIT_W:0] payload,
                                        input logic            par_bit);
        return ^{payload, par_bit};
    endfunction
`endif

    state_t               state_r;
    state_t               state_n;
    logic [SYNC_W-1:0]    win_r;
    logic [SYNC_W-1:0]    win_n;
    logic [SYNC_W-1:0]    win_shift_s;
    logic [CW-1:0]        cnt_r;
    logic [CW-1:0]        cnt_n;
    // Staging: bits [INIT_W:1] hold INIT (MSB first on the wire), bit 0 holds S.
    logic [INIT_W:0]      stage_r;
    logic [INIT_W:0]      stage_n;
    logic [INIT_W:0]      stage_shift_s;
    logic [INIT_W-1:0]    init_r;
    logic [INIT_W-1:0]    init_n;
    logic                 s_r;
    logic                 s_n;
    logic                 done_r;
    logic                 done_n;
    logic                 err_r;
    logic                 err_n;
    logic                 busy_r;
    logic                 busy_n;

    // FSM state register.
    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state and datapath next-value logic; nothing moves unless DV=1.
    always_comb begin
        state_n       = state_r;
        win_n         = win_r;
        cnt_n         = cnt_r;
        stage_n       = stage_r;
        init_n        = init_r;
        s_n           = s_r;
        done_n        = 1'b0;
        err_n         = 1'b0;
        win_shift_s   = {win_r[SYNC_W-2:0], bus.DI};
        stage_shift_s = {stage_r[INIT_W-1:0], bus.DI};

        if (bus.DV) begin
            case (state_r)
                ST_HUNT: begin
                    // The window compared includes the bit arriving on this edge.
                    if (win_shift_s == SYNC) begin
                        state_n = ST_LOAD;
                        cnt_n   = {CW{1'b0}};
                        stage_n = {(INIT_W+1){1'b0}};
                        // Window restarts empty so the next hunt cannot reuse
                        // stale sync bits from this frame.
                        win_n   = {SYNC_W{1'b0}};
                    end else begin
                        win_n   = win_shift_s;
                    end
                end

                ST_LOAD: begin
                    stage_n = stage_shift_s;
                    if (cnt_r == LAST_IDX) begin
`ifdef LUT_CFG_LOADER_PARITY_EN
                        state_n = ST_CHECK;
                        cnt_n   = {CW{1'b0}};
`else
                        state_n = ST_HUNT;
                        cnt_n   = {CW{1'b0}};
                        init_n  = stage_shift_s[INIT_W:1];
                        s_n     = stage_shift_s[0];
                        done_n  = 1'b1;
`endif
                    end else begin
                        cnt_n   = cnt_r + CNT_ONE;
                    end
                end

`ifdef LUT_CFG_LOADER_PARITY_EN
                ST_CHECK: begin
                    state_n = ST_HUNT;
                    cnt_n   = {CW{1'b0}};
                    if (parity_bad(stage_r, bus.DI)) begin
                        err_n  = 1'b1;
                    end else begin
                        init_n = stage_r[INIT_W:1];
                        s_n    = stage_r[0];
                        done_n = 1'b1;
                    end
                end
`endif

                default: begin
                    state_n = ST_HUNT;
                    win_n   = {SYNC_W{1'b0}};
                    cnt_n   = {CW{1'b0}};
                end
            endcase
        end else begin
            state_n = state_r;
        end

        busy_n = (state_n != ST_HUNT);
    end

    // Datapath and output registers; outputs change only on C edges.
    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            win_r   <= {SYNC_W{1'b0}};
            cnt_r   <= {CW{1'b0}};
            stage_r <= {(INIT_W+1){1'b0}};
            init_r  <= {INIT_W{1'b0}};
            s_r     <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            win_r   <= win_n;
            cnt_r   <= cnt_n;
            stage_r <= stage_n;
            init_r  <= init_n;
            s_r     <= s_n;
            done_r  <= done_n;
            err_r   <= err_n;
            busy_r  <= busy_n;
        end
    end

    assign bus.INIT = init_r;
    assign bus.S    = s_r;
    assign bus.DONE = done_r;
    assign bus.ERR  = err_r;
    assign bus.BUSY = busy_r;

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Bench for lut_cfg_loader. A queue-based stream model decides, bit by bit,
// what INIT/S/DONE/ERR/BUSY must look like after every clock edge; directed
// frames from the test plan are followed by randomized frames with random
// garbage prefixes and random DV gaps.
module tb_lut_cfg_loader;

    localparam int         K      = 4;
    localparam int         INIT_W = 16;
    localparam int         SYNC_W = 8;
    localparam logic [7:0] SYNC   = 8'hA5;
`ifdef LUT_CFG_LOADER_PARITY_EN
    localparam int         FRAME_BITS = INIT_W + 2;
`else
    localparam int         FRAME_BITS = INIT_W + 1;
`endif

    logic C  = 1'b0;
    logic RN = 1'b0;

    lut_cfg_loader_if #(.K(K)) bus ();

    lut_cfg_loader #(.K(K), .SYNC_W(SYNC_W), .SYNC(SYNC)) dut (
        .C   (C),
        .RN  (RN),
        .bus (bus)
    );

    always #5 C = ~C;

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen;
    int err_seen;

    // Reference model state.
    bit          m_hunting;
    logic [7:0]  m_win;
    bit          m_q[$];
    logic [15:0] m_init;
    logic        m_s;
    logic        m_done;
    logic        m_err;
    logic        m_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hunting = 1'b1;
        m_win     = 8'h00;
        m_q.delete();
        m_init    = 16'h0000;
        m_s       = 1'b0;
        m_done    = 1'b0;
        m_err     = 1'b0;
        m_busy    = 1'b0;
    endtask

    task automatic model_step(input logic dv, input logic di);
        int ones;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (dv) begin
            if (m_hunting) begin
                m_win = {m_win[6:0], di};
                if (m_win == SYNC) begin
                    m_hunting = 1'b0;
                    m_busy    = 1'b1;
                    m_q.delete();
                end
            end else begin
                m_q.push_back(di);
                if (m_q.size() == FRAME_BITS) begin
                    ones = 0;
                    foreach (m_q[i]) ones += int'(m_q[i]);
`ifdef LUT_CFG_LOADER_PARITY_EN
                    if ((ones % 2) == 0) begin
`else
                    if (ones >= 0) begin
`endif
                        for (int i = 0; i < INIT_W; i++) m_init[INIT_W-1-i] = m_q[i];
                        m_s    = m_q[INIT_W];
                        m_done = 1'b1;
                    end else begin
                        m_err  = 1'b1;
                    end
                    m_hunting = 1'b1;
                    m_win     = 8'h00;
                    m_busy    = 1'b0;
                    m_q.delete();
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".INIT"}, 32'(bus.INIT), 32'(m_init));
        chk({tag, ".S"},    32'(bus.S),    32'(m_s));
        chk({tag, ".DONE"}, 32'(bus.DONE), 32'(m_done));
        chk({tag, ".ERR"},  32'(bus.ERR),  32'(m_err));
        chk({tag, ".BUSY"}, 32'(bus.BUSY), 32'(m_busy));
    endtask

    // One clock: drive inputs, step model on the edge, check 1 time unit later.
    task automatic cycle(input string tag, input logic dv, input logic di);
        bus.DV = dv;
        bus.DI = di;
        @(posedge C);
        model_step(dv, di);
        #1;
        check_all(tag);
        if (bus.DONE === 1'b1) done_seen++;
        if (bus.ERR === 1'b1) err_seen++;
    endtask

    task automatic send_bits(input string tag, input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) cycle(tag, 1'b1, v[i]);
    endtask

    // Full frame; bad_par selects a deliberately wrong parity bit.
    task automatic send_frame(input string tag, input logic [15:0] init, input logic s,
                              input bit bad_par, input int gap_every, input int gap_len);
        bit bits[$];
        logic p;
        for (int i = 7; i >= 0; i--) bits.push_back(SYNC[i]);
        for (int i = 15; i >= 0; i--) bits.push_back(init[i]);
        bits.push_back(s);
`ifdef LUT_CFG_LOADER_PARITY_EN
        p = ^{init, s};
        if (bad_par) p = ~p;
        bits.push_back(p);
`else
        p = bad_par;
`endif
        for (int i = 0; i < bits.size(); i++) begin
            cycle(tag, 1'b1, bits[i]);
            if (gap_every > 0 && ((i + 1) % gap_every) == 0 && (i + 1) < bits.size())
                for (int g = 0; g < gap_len; g++) cycle({tag, "_gap"}, 1'b0, 1'($urandom_range(1)));
        end
    endtask

    initial begin
        bus.DI = 1'b0;
        bus.DV = 1'b0;
        model_reset();

        // Reset, then idle.
        repeat (2) begin
            @(posedge C);
            #1;
            check_all("reset");
        end
        @(negedge C);
        RN = 1'b1;
        for (int i = 0; i < 10; i++) cycle("idle", 1'b0, 1'($urandom_range(1)));

        // Clean frame, DV continuous.
        done_seen = 0;
        send_frame("clean", 16'hCAFE, 1'b1, 1'b0, 0, 0);
        chk("clean_init_lit", 32'(bus.INIT), 32'h0000_CAFE);
        chk("clean_s_lit", 32'(bus.S), 32'h1);
        repeat (3) cycle("clean_tail", 1'b0, 1'b0);
        chk("clean_done_count", 32'(done_seen), 32'd1);

        // Gapped frame: 3 idle cycles after every 4th bit.
        done_seen = 0;
        send_frame("gapped", 16'hCAFE, 1'b1, 1'b0, 4, 3);
        chk("gapped_init_lit", 32'(bus.INIT), 32'h0000_CAFE);
        repeat (3) cycle("gapped_tail", 1'b0, 1'b0);
        chk("gapped_done_count", 32'(done_seen), 32'd1);

        // Sync hunt behind garbage 110.
        send_bits("garbage", 32'b110, 3);
        chk("garbage_no_lock", 32'(bus.BUSY), 32'h0);
        send_frame("hunt", 16'h8001, 1'b0, 1'b0, 0, 0);
        chk("hunt_init_lit", 32'(bus.INIT), 32'h0000_8001);
        cycle("hunt_tail", 1'b0, 1'b0);

`ifdef LUT_CFG_LOADER_PARITY_EN
        // Parity: good frame commits, wrong-parity frame is rejected.
        done_seen = 0;
        err_seen  = 0;
        send_frame("par_good", 16'h0003, 1'b0, 1'b0, 0, 0);
        chk("par_good_init", 32'(bus.INIT), 32'h0000_0003);
        cycle("par_good_tail", 1'b0, 1'b0);
        send_frame("par_bad", 16'hFFFF, 1'b1, 1'b1, 0, 0);
        chk("par_bad_err", 32'(bus.ERR), 32'h1);
        chk("par_bad_init", 32'(bus.INIT), 32'h0000_0003);
        chk("par_bad_s", 32'(bus.S), 32'h0);
        cycle("par_bad_tail", 1'b0, 1'b0);
        chk("par_done_count", 32'(done_seen), 32'd1);
        chk("par_err_count", 32'(err_seen), 32'd1);
`endif

        // Reset mid-frame discards the partial frame and the old config.
        send_frame("pre_rst", 16'h1234, 1'b1, 1'b0, 0, 0);
        chk("pre_rst_init", 32'(bus.INIT), 32'h0000_1234);
        send_bits("part_sync", 32'(SYNC), 8);
        send_bits("part_init", 32'h1FF, 9);
        chk("part_busy", 32'(bus.BUSY), 32'h1);
        #2;
        RN = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        chk("async_rst_init", 32'(bus.INIT), 32'h0);
        @(posedge C);
        #1;
        check_all("rst_hold");
        @(negedge C);
        RN = 1'b1;
        send_frame("post_rst", 16'h5678, 1'b0, 1'b0, 0, 0);
        chk("post_rst_init", 32'(bus.INIT), 32'h0000_5678);
        cycle("post_rst_tail", 1'b0, 1'b0);

        // Randomized frames with random garbage prefixes and gaps.
        for (int r = 0; r < 8; r++) begin
            int nj;
            nj = int'($urandom_range(5));
            for (int j = 0; j < nj; j++) cycle("rnd_junk", 1'b1, 1'($urandom_range(1)));
            send_frame("rnd", 16'($urandom), 1'($urandom_range(1)), bit'($urandom_range(1)),
                       int'($urandom_range(6)), int'($urandom_range(3)));
            repeat (2) cycle("rnd_tail", 1'b0, 1'($urandom_range(1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
